// File: rtl/spi_bridge_if.sv
// SPI pin and decoder-side byte signals of the PWM register access bridge.
// The bridge uses the slave modport; the SPI master and decoder side uses the master modport.
interface spi_bridge_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport slave (
    input  sclk, cs_n, mosi, data_out,
    output miso, byte_sync, data_in
  );

  modport master (
    output sclk, cs_n, mosi, data_out,
    input  miso, byte_sync, data_in
  );
endinterface

// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end: oversamples sclk/cs_n/mosi in the clk domain,
// assembles MSB-first bytes for the decoder and shifts data_out back out on miso.
module spi_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_bridge_if.slave  bus
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_d_q;

  logic sync_sclk;
  logic sync_cs_n;
  logic sync_mosi;
  logic rise;
  logic fall;

  state_e      state_q,     state_d;
  logic [2:0]  bit_cnt_q,   bit_cnt_d;
  logic [6:0]  rx_shift_q,  rx_shift_d;
  logic [7:0]  tx_shift_q,  tx_shift_d;
  logic [7:0]  data_in_q,   data_in_d;
  logic        byte_sync_q, byte_sync_d;
  logic        miso_q,      miso_d;

  // cs_n chain resets high so the bridge starts out deselected.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_d_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_d_q    <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_sclk = sclk_sync_q[SYNC_STAGES-1];
  assign sync_cs_n = cs_sync_q[SYNC_STAGES-1];
  assign sync_mosi = mosi_sync_q[SYNC_STAGES-1];
  assign rise      =  sync_sclk & ~sclk_d_q;
  assign fall      = ~sync_sclk &  sclk_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 8'd0;
      data_in_q   <= 8'd0;
      byte_sync_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      data_in_q   <= data_in_d;
      byte_sync_q <= byte_sync_d;
      miso_q      <= miso_d;
    end
  end

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    data_in_d   = data_in_q;
    byte_sync_d = 1'b0;
    miso_d      = sync_cs_n ? 1'b0 : tx_shift_q[7];

    unique case (state_q)
      IDLE: begin
        bit_cnt_d  = 3'd0;
        tx_shift_d = bus.data_out;
        if (!sync_cs_n) state_d = ACTIVE;
      end
      ACTIVE: begin
        // A deassert seen together with an edge drops the edge and any partial byte.
        if (sync_cs_n) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
        end else begin
          if (rise) begin
            rx_shift_d = {rx_shift_q[5:0], sync_mosi};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_in_d   = {rx_shift_q, sync_mosi};
              byte_sync_d = 1'b1;
            end
          end else if (bit_cnt_q == 3'd0) begin
            // Reload window stays open until the first rise so a late data_out is caught.
            tx_shift_d = bus.data_out;
          end
          if (fall && bit_cnt_q != 3'd0) tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.miso      = miso_q;
  assign bus.byte_sync = byte_sync_q;
  assign bus.data_in   = data_in_q;

endmodule

// File: tb/tb_spi_bridge.sv
// Self-checking bench for spi_bridge: table of single-byte frames plus hand-written
// multi-cycle sequences; received bytes are checked against a scoreboard queue.
module tb_spi_bridge;

  localparam int SYNC_STAGES = 2;
  localparam int CLK_PER     = 10;

  logic clk;
  logic rst_n;
  spi_bridge_if bus ();

  spi_bridge #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #(CLK_PER / 2) clk = ~clk;

  typedef struct {
    logic [7:0] mosi_byte;
    logic [7:0] dout_byte;
    logic [7:0] exp_miso;
  } vec_t;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         sync_cnt = 0;
  logic [7:0] exp_q[$];
  time        last_rise_t = 0;
  logic       prev_sync = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every byte_sync pops the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && bus.byte_sync) begin
      sync_cnt++;
      check("sync_width", {31'd0, prev_sync}, 32'd0);
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("data_in", {24'd0, bus.data_in}, {24'd0, exp_q.pop_front()});
      check("latency_ok",
            {31'd0, (($time - last_rise_t) / CLK_PER >= SYNC_STAGES + 1) &&
                    (($time - last_rise_t) / CLK_PER <= SYNC_STAGES + 3)}, 32'd1);
    end
    prev_sync = rst_n & bus.byte_sync;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifts the top nbits of b out on mosi (MSB first); miso sampled at each rising edge.
  task automatic xfer(input logic [7:0] b, input int nbits, input int half, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.mosi = b[i];
      wait_cyc(half);
      rx = {rx[6:0], bus.miso};
      bus.sclk = 1'b1;
      if (i == 0) last_rise_t = $time;
      wait_cyc(half);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input int half, output logic [7:0] rx);
    exp_q.push_back(b);
    xfer(b, 8, half, rx);
  endtask

  vec_t       vecs[5];
  logic [7:0] rx0, rx1;
  int         base;
  int         n;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h85, 8'hA5, 8'hA5};
    vecs[1] = '{8'h3C, 8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{8'h00, 8'h81, 8'h81};
    vecs[4] = '{8'h5A, 8'h3C, 8'h3C};

    rst_n = 1'b0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.data_out = 8'h00;
    wait_cyc(3);
    check("rst_miso", {31'd0, bus.miso}, 32'd0);
    check("rst_byte_sync", {31'd0, bus.byte_sync}, 32'd0);
    check("rst_data_in", {24'd0, bus.data_in}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Single-byte frames: data_out preset in IDLE, checked on miso and data_in.
    foreach (vecs[k]) begin
      base = sync_cnt;
      bus.data_out = vecs[k].dout_byte;
      wait_cyc(3);
      bus.cs_n = 1'b0;
      spi_byte(vecs[k].mosi_byte, 8, rx0);
      wait_cyc(8);
      bus.cs_n = 1'b1;
      wait_cyc(6);
      check("vec_miso", {24'd0, rx0}, {24'd0, vecs[k].exp_miso});
      check("vec_data_in", {24'd0, bus.data_in}, {24'd0, vecs[k].mosi_byte});
      check("vec_sync_cnt", sync_cnt - base, 32'd1);
    end

    // Write frame: two back-to-back bytes under one cs_n.
    base = sync_cnt;
    bus.cs_n = 1'b0;
    spi_byte(8'h85, 8, rx0);
    spi_byte(8'h3C, 8, rx1);
    wait_cyc(8);
    bus.cs_n = 1'b1;
    wait_cyc(10);
    check("wr_sync_cnt", sync_cnt - base, 32'd2);
    check("wr_data_in_hold", {24'd0, bus.data_in}, 32'h3C);

    // data_out changed two cycles after the first byte_sync feeds the second byte.
    bus.data_out = 8'h00;
    wait_cyc(3);
    bus.cs_n = 1'b0;
    fork
      begin
        spi_byte(8'h12, 8, rx0);
        spi_byte(8'h34, 8, rx1);
      end
      begin
        n = 0;
        while (!bus.byte_sync && n < 300) begin
          wait_cyc(1);
          n++;
        end
        check("mid_sync_seen", {31'd0, n < 300}, 32'd1);
        wait_cyc(2);
        bus.data_out = 8'h5A;
      end
    join
    wait_cyc(8);
    bus.cs_n = 1'b1;
    wait_cyc(6);
    check("mid_first_miso", {24'd0, rx0}, 32'h00);
    check("mid_second_miso", {24'd0, rx1}, 32'h5A);

    // Abort after 5 rises, then a full byte.
    base = sync_cnt;
    bus.cs_n = 1'b0;
    xfer(8'hAB, 5, 8, rx0);
    wait_cyc(8);
    bus.cs_n = 1'b1;
    wait_cyc(8);
    check("abort_no_sync", sync_cnt - base, 32'd0);
    check("abort_data_in_kept", {24'd0, bus.data_in}, 32'h34);
    bus.cs_n = 1'b0;
    spi_byte(8'hF0, 8, rx0);
    wait_cyc(8);
    bus.cs_n = 1'b1;
    wait_cyc(8);
    check("abort_sync_cnt", sync_cnt - base, 32'd1);
    check("abort_data_in", {24'd0, bus.data_in}, 32'hF0);

    // Reset in the middle of a byte.
    bus.data_out = 8'hFF;
    wait_cyc(3);
    bus.cs_n = 1'b0;
    xfer(8'hC3, 4, 8, rx0);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wait_cyc(1);
      check("mrst_miso", {31'd0, bus.miso}, 32'd0);
      check("mrst_byte_sync", {31'd0, bus.byte_sync}, 32'd0);
      check("mrst_data_in", {24'd0, bus.data_in}, 32'd0);
    end
    rst_n = 1'b1;
    bus.cs_n = 1'b1;
    wait_cyc(4);
    base = sync_cnt;
    bus.cs_n = 1'b0;
    spi_byte(8'h11, 8, rx0);
    wait_cyc(8);
    bus.cs_n = 1'b1;
    wait_cyc(8);
    check("mrst_sync_cnt", sync_cnt - base, 32'd1);
    check("mrst_data_in_after", {24'd0, bus.data_in}, 32'h11);

    // Minimum clock ratio: 16 bytes back to back at clk = 8x sclk.
    base = sync_cnt;
    bus.cs_n = 1'b0;
    wait_cyc(4);
    for (int b = 0; b < 16; b++) spi_byte(8'(b), 4, rx0);
    wait_cyc(4);
    bus.cs_n = 1'b1;
    wait_cyc(10);
    check("min_sync_cnt", sync_cnt - base, 32'd16);
    check("min_data_in", {24'd0, bus.data_in}, 32'h0F);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_bridge.md
Name: spi_bridge

Overview:
- SPI slave front end (mode 0: CPOL=0, CPHA=0, MSB first) for the PWM generator's register access path.
- Oversamples the external sclk, cs_n and mosi pins in the peripheral clock domain and assembles 8-bit frames.
- Delivers each received byte to the instruction decoder with a one-cycle byte_sync strobe.
- Serialises the decoder's data_out byte onto miso.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in each input synchronizer for sclk, cs_n and mosi (legal values 2 or 3).

Ports:
- clk  input  1  peripheral clock; must run at least 8x the sclk frequency.
- rst_n  input  1  reset; asynchronous, active-low.
- sclk  input  1  SPI serial clock from the master; asynchronous to clk.
- cs_n  input  1  SPI chip select, active-low; asynchronous to clk.
- mosi  input  1  SPI master-out data; asynchronous to clk.
- miso  output  1  SPI master-in data.
- byte_sync  output  1  one-clk strobe: data_in holds a newly completed byte.
- data_in  output  8  last received byte, toward the decoder.
- data_out  input  8  byte to transmit, from the decoder.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n. All state is in the clk domain.
- Synchronizers: sclk, cs_n and mosi each pass through SYNC_STAGES flops. In reset, the sclk and mosi chains reset to 0 and the cs_n chain resets to 1.
- Edge detection:
  - rise = sync_sclk & ~sclk_d; fall = ~sync_sclk & sclk_d. sclk_d is a one-flop delay of sync_sclk.
  - Edges count only while sync_cs_n = 0.
- Reset values: miso=0, byte_sync=0, data_in=8'h00. Internal: bit_cnt=0, rx_shift=0, tx_shift=0, state=IDLE.
- States:
  - IDLE (sync_cs_n=1): bit_cnt held at 0; tx_shift reloaded from data_out every cycle; edges ignored. Leave to ACTIVE when sync_cs_n goes 0.
  - ACTIVE: rise and fall events are processed as described below.
  - Return to IDLE on sync_cs_n = 1.
- Receive: on rise, rx_shift <= {rx_shift[6:0], sync_mosi} and bit_cnt <= bit_cnt+1 (3-bit, wraps 7->0).
- Byte completion:
  - Occurs on the rise where bit_cnt = 7.
  - The next cycle has data_in = {rx_shift[6:0], sync_mosi} and byte_sync = 1, exactly one clk cycle wide.
  - data_in holds its value until the next completed byte.
- Transmit:
  - While bit_cnt = 0 and no rise has yet occurred for the current byte, tx_shift reloads from data_out every clk cycle. This lets a data_out update issued 1-2 cycles after byte_sync be picked up for the following byte.
  - The reload stops at the first rise of a byte.
  - On each fall with bit_cnt != 0: tx_shift <= {tx_shift[6:0], 1'b0}.
  - miso = tx_shift[7] when sync_cs_n = 0, otherwise 0. miso is registered and never tristated.
- Back-to-back bytes: with cs_n held low, bit_cnt wraps to 0 after the 8th rise. The reload window then reopens until the next rise; the fall after the 8th rise does not shift.
- cs_n deassert mid-byte (bit_cnt != 0): the partial byte is discarded, no byte_sync, bit_cnt <= 0, data_in unchanged.
- Simultaneous events: if a rise and a sync_cs_n rising transition are seen in the same cycle, the deassert wins and the edge is dropped.
- Reset mid-operation: all state returns to reset values immediately. The first byte after rst_n release starts only after sync_cs_n has been observed high (IDLE) and then low again.
- Latency: byte_sync is asserted SYNC_STAGES+2 clk cycles after the 8th sclk rising edge at the pin (±1 cycle of sampling uncertainty).
- Decoder timing: byte_sync is never asserted for more than one cycle, so the decoder sees exactly one event per byte.

Test Plan:
- Write frame: cs_n low, send 0x85 then 0x3C at clk/16 sclk, cs_n high -> exactly two byte_sync pulses; data_in=0x85 at the first and 0x3C at the second; data_in stays 0x3C afterwards.
- Read transmit: data_out=0xA5 held from IDLE, one byte clocked -> miso sampled on sclk rising edges = 1,0,1,0,0,1,0,1.
- Mid-frame data_out update: data_out changes 0x00->0x5A two clk cycles after the first byte_sync -> second byte on miso = 0x5A.
- Abort: cs_n high after 5 sclk rises, then a full byte 0xF0 -> no byte_sync for the partial byte, one byte_sync with data_in=0xF0.
- Reset mid-byte: rst_n low for 3 cycles after 4 bits -> miso=0, byte_sync=0, data_in=0x00. A following cs_n high/low and byte 0x11 gives data_in=0x11.
- Minimum ratio: clk = 8x sclk, 16 consecutive bytes 0x00..0x0F under one cs_n -> 16 byte_sync pulses in order with no drops.
